// File: rtl/seg_display_if.sv
// seg_display_if: calculator result in, multiplexed 7-segment drive and busy out
interface seg_display_if;
  logic [27:0] value;
  logic        sign;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        busy;
  modport master(output value, sign, input an, seg, busy);
  modport slave(input value, sign, output an, seg, busy);
endinterface

// File: rtl/seg_display.sv
// seg_display: serial double-dabble BCD conversion of a signed result, shown on an 8-digit scanned 7-segment display
module seg_display #(
  parameter int REFRESH_W = 16
) (
  input logic          clk,
  input logic          rst,
  seg_display_if.slave bus
);
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  typedef enum logic {IDLE, CONV} state_t;
  state_t state, state_nx;
  logic [27:0] cap_val, shf;
  logic cap_sign, start, done;
  logic [31:0] work, work_adj, work_nx, bcd;
  logic [4:0] step;
  logic sign_r, ovf;
  logic [REFRESH_W-1:0] scan;
  logic [2:0] idx, msd;
  logic [3:0] dig;
  logic err, neg;
  logic [6:0] seg_nx;
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 7'b1000000;
      4'd1: enc = 7'b1111001;
      4'd2: enc = 7'b0100100;
      4'd3: enc = 7'b0110000;
      4'd4: enc = 7'b0011001;
      4'd5: enc = 7'b0010010;
      4'd6: enc = 7'b0000010;
      4'd7: enc = 7'b1111000;
      4'd8: enc = 7'b0000000;
      4'd9: enc = 7'b0010000;
      default: enc = SEG_BLANK;
    endcase
  endfunction
  assign start = state == IDLE && bus.value != cap_val;
  assign done = state == CONV && step == 5'd27;
  assign bus.busy = state == CONV;
  always_comb state_nx = start ? CONV : done ? IDLE : state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  for (genvar i = 0; i < 8; i++) begin : g_adj
    assign work_adj[4*i +: 4] = work[4*i +: 4] >= 4'd5 ? work[4*i +: 4] + 4'd3 : work[4*i +: 4];
  end
  assign work_nx = {work_adj[30:0], shf[27]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cap_val <= '0;
      cap_sign <= 1'b1;
      shf <= '0;
      work <= '0;
      step <= '0;
      bcd <= '0;
      sign_r <= 1'b1;
      ovf <= 1'b0;
    end else begin
      if (start) begin
        cap_val <= bus.value;
        cap_sign <= bus.sign;
        shf <= bus.value;
        work <= '0;
        step <= '0;
      end else if (state == CONV) begin
        shf <= {shf[26:0], 1'b0};
        work <= work_nx;
        step <= step + 5'd1;
      end
      if (done) begin
        bcd <= work_nx;
        sign_r <= cap_sign;
        ovf <= cap_val > 28'd99_999_999;
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      scan <= '0;
      idx <= '0;
    end else begin
      scan <= scan + 1'b1;
      if (&scan) idx <= idx + 3'd1;
    end
  always_comb begin
    msd = '0;
    for (int k = 1; k < 8; k++) if (bcd[4*k +: 4] != 4'd0) msd = 3'(k);
  end
  assign dig = bcd[{idx, 2'b00} +: 4];
  assign neg = ~sign_r & (|bcd);
  assign err = ovf | (~sign_r & msd == 3'd7);
  // a minus at msd+1 can never wrap to digit 0: a negative 8-digit value is already an error
  always_comb
    seg_nx = err ? (idx == 3'd2 ? SEG_E : idx < 3'd2 ? SEG_R : SEG_BLANK)
           : idx <= msd ? enc(dig)
           : (neg && idx == msd + 3'd1) ? SEG_MINUS : SEG_BLANK;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.an <= 8'hFF;
      bus.seg <= 7'h7F;
    end else begin
      bus.an <= ~(8'b1 << idx);
      bus.seg <= seg_nx;
    end
endmodule

// File: doc/seg_display.md
SEG_DISPLAY -- requirements
Module: seg_display

Interface
REQ-001 Parameter: REFRESH_W, default 16, digit-scan period exponent; each digit is driven for 2^REFRESH_W clk cycles.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 value  input  28  unsigned magnitude of the calculator result to display.
REQ-005 sign  input  1  1 = positive, 0 = negative.
REQ-006 an  output  8  active-low digit enables, registered; an[0] is the rightmost digit.
REQ-007 seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered.
REQ-008 busy  output  1  high while a binary-to-BCD conversion is in progress.

Function
REQ-009 Two-state converter FSM shall be used: IDLE and CONV.
REQ-010 In IDLE, when value differs from the last captured value, the block shall capture value and sign at that edge (E0) and go to CONV.
REQ-011 CONV shall run double-dabble, one shift per edge, on edges E1..E28: add 3 to each BCD nibble >= 5, then shift left one bit, taking in the next binary MSB.
REQ-012 At E28, the FSM shall return to IDLE and load the display registers: bcd[31:0] with 8 digits, sign, and ovf (= captured value > 99_999_999).
REQ-013 busy shall be high in CONV only, i.e. for exactly 28 cycles per conversion.
REQ-014 value/sign changes during CONV shall be ignored; the comparison resumes in IDLE, so the earliest recapture is at E29.
REQ-015 Scan: a REFRESH_W-bit counter shall increment every cycle; the 3-bit digit index shall increment, wrapping 7->0, when the counter wraps.
REQ-016 an shall be one-hot low at the digit index; exactly one an bit is low at any time after reset.
REQ-017 msd = index of the highest nonzero BCD digit, or 0 if all digits are zero.
REQ-018 Normal display: digits 0..msd show their BCD value; higher digits are blank.
REQ-019 Minus: if sign=0 and magnitude is nonzero, digit msd+1 shows '-'; a zero magnitude always displays as '0' (no -0).
REQ-020 Error display ("Err" on digits 2,1,0 = E,r,r, rest blank) shall be shown if ovf=1, or if sign=0 and msd=7.
REQ-021 Segment codes (seg, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, '-'=0111111, E=0000110, r=0101111, blank=1111111.
REQ-022 an/seg shall reflect the display registers and digit index with one cycle of registration latency.
REQ-023 The display shall only change at the E28 load, never mid-conversion; the previous image remains shown during CONV.

Reset
REQ-024 While rst=0: FSM=IDLE, busy=0, captured value=0, bcd=0, sign reg=1, ovf=0, scan counter=0, digit index=0, an=8'hFF, seg=7'h7F.
REQ-025 First edge after release shall drive an=8'b11111110, seg=1000000 ('0').
REQ-026 Reset asserted mid-conversion shall abort it; after release the display shows '0', and a nonzero value is captured on the first IDLE edge.

Verification (bench uses REFRESH_W=2)
REQ-027 Reset, value=0, sign=1 -> busy never rises; digit0 '0', digits 1..7 blank, an walks 0..7 every 4 cycles.
REQ-028 value=1234, sign=1 -> busy high 28 cycles; then digits 3..0 = 1,2,3,4 and 7..4 blank.
REQ-029 value=5, sign=0 -> digit1 '-', digit0 '5'; value=0, sign=0 -> digit0 '0', no '-'.
REQ-030 value=100_000_000 -> Err; value=99_999_999, sign=0 -> Err; value=99_999_999, sign=1 -> eight '9'.
REQ-031 value 42 -> 77 changed at E10 of conversion -> '42' displayed at E28, recapture at E29, '77' displayed 28 edges later.
REQ-032 rst pulsed low at E15 while converting 1234 -> an=FF/seg=7F during reset, then '0', then 1234 displayed 29 edges after release.
